// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised WIDTH-bit input, per-bit edge capture (W1C),
// per-bit interrupt mask and a level irq built only from registered state.
module pio_in_edge_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync = in_port;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= in_port;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        det = '0;
        case (EDGE_TYPE)
            0:       det = sync & ~prev_q;
            1:       det = ~sync & prev_q;
            default: det = (sync & ~prev_q) | (~sync & prev_q);
        endcase
    end

    // Bus contract: no wait states; chipselect qualifies writes only, reads
    // are registered every cycle from address and land one clock later.
    assign wr_en = chipselect & write;
    assign w1c   = (wr_en && address == ADDR_CAP) ? writedata[WIDTH-1:0] : '0;

    // A new edge in the same cycle as its W1C keeps the bit set.
    always_comb begin
        cap_d  = (cap_q & ~w1c) | det;
        mask_d = mask_q;
        if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = sync;
            ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_CAP:  readdata_d[WIDTH-1:0] = cap_q;
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= sync;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata     = readdata_q;
    assign irq          = |(cap_q & mask_q);
    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: four builds (rise/fall/any with 2 sync stages, any
// with no synchroniser) driven in lockstep and checked against a history model.
module tb_pio_in_edge_irq;

    localparam int W = 8;
    localparam int NI = 4;
    localparam int S_OF [NI] = '{2, 2, 2, 0};
    localparam int E_OF [NI] = '{0, 1, 2, 2};

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         chipselect = 1'b0;
    logic         write = 1'b0;
    logic [1:0]   address = 2'd0;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  rd0, rd1, rd2, rd3;
    logic         irq0, irq1, irq2, irq3;

    pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));
    pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));
    pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));
    pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(0), .EDGE_TYPE(2)) u_any_nosync (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd3), .irq(irq3));

    int n_chk = 0;
    int n_fail = 0;

    // reference model: full input history indexed by clock edge
    logic [32:0]  exp_q [$];
    logic [W-1:0] hist [0:4095];
    int           t = 0;
    int           last_rst = -100;
    logic [W-1:0] cap_m [NI];
    logic [W-1:0] mask_m;

    function automatic logic [W-1:0] sync_at(int s, int k);
        if (s == 0) return hist[k];
        if (k - s < 0 || last_rst >= k - s) return '0;
        return hist[k - s];
    endfunction

    function automatic logic [W-1:0] prev_at(int s, int k);
        if (k < 1 || last_rst >= k - 1) return '0;
        return sync_at(s, k - 1);
    endfunction

    function automatic logic [W-1:0] edges(int e, logic [W-1:0] s, logic [W-1:0] p);
        logic [W-1:0] rise, fall;
        rise = s & ~p;
        fall = ~s & p;
        if (e == 0) return rise;
        if (e == 1) return fall;
        return rise | fall;
    endfunction

    task automatic model_edge(input logic r, input logic c, input logic w,
                              input logic [1:0] a, input logic [31:0] d,
                              input logic [W-1:0] p);
        logic [W-1:0] s, pv, new_mask;
        logic [31:0]  rd;
        hist[t] = p;
        if (r) begin
            for (int i = 0; i < NI; i++) begin
                cap_m[i] = '0;
                exp_q.push_back(33'h0);
            end
            mask_m = '0;
            last_rst = t;
        end else begin
            new_mask = (c && w && a == 2'd2) ? d[W-1:0] : mask_m;
            for (int i = 0; i < NI; i++) begin
                s  = sync_at(S_OF[i], t);
                pv = prev_at(S_OF[i], t);
                case (a)
                    2'd0:    rd = {24'h0, s};
                    2'd2:    rd = {24'h0, mask_m};
                    2'd3:    rd = {24'h0, cap_m[i]};
                    default: rd = 32'h0;
                endcase
                if (c && w && a == 2'd3) cap_m[i] = cap_m[i] & ~d[W-1:0];
                cap_m[i] = cap_m[i] | edges(E_OF[i], s, pv);
                exp_q.push_back({|(cap_m[i] & new_mask), rd});
            end
            mask_m = new_mask;
        end
        t++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, t - 1, act, exp);
        end
    endtask

    // scoreboard: pop one {irq, readdata} per instance
    task automatic check_outputs();
        logic [31:0] rds [NI];
        logic        irqs [NI];
        logic [32:0] e;
        rds  = '{rd0, rd1, rd2, rd3};
        irqs = '{irq0, irq1, irq2, irq3};
        for (int i = 0; i < NI; i++) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_empty inst %0d: got no entry expected one", i);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("readdata[%0d]", i), rds[i], e[31:0]);
                chk($sformatf("irq[%0d]", i), {31'h0, irqs[i]}, {31'h0, e[32]});
            end
        end
    endtask

    // driver
    task automatic cycle(input logic r, input logic c, input logic w,
                         input logic [1:0] a, input logic [31:0] d,
                         input logic [W-1:0] p);
        @(negedge clk);
        reset = r; chipselect = c; write = w; address = a; writedata = d; in_port = p;
        @(posedge clk);
        model_edge(r, c, w, a, d, p);
        #1;
        check_outputs();
    endtask

    task automatic hold(input logic [W-1:0] p, input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, p);
    endtask

    task automatic read_cap(input string nm, input logic [W-1:0] p,
                            input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3);
        cycle(1'b0, 1'b1, 1'b0, 2'd3, 32'h0, p);
        chk({nm, "_rise"}, rd0, {24'h0, e0});
        chk({nm, "_fall"}, rd1, {24'h0, e1});
        chk({nm, "_any"}, rd2, {24'h0, e2});
        chk({nm, "_any_nosync"}, rd3, {24'h0, e3});
    endtask

    typedef struct {
        logic        r, c, w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [7:0]  p;
        logic [31:0] erd;
        logic        eirq;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic r, input logic c, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic [7:0] p,
                       input logic [31:0] erd, input logic eirq);
        vec_t v;
        v.r = r; v.c = c; v.w = w; v.a = a; v.d = d; v.p = p; v.erd = erd; v.eirq = eirq;
        tbl.push_back(v);
    endtask

    initial begin
        // expected values are for the rising-edge, two-stage build
        add(1, 0, 0, 0, 32'h0,        8'h00, 32'h00, 0);
        add(1, 0, 0, 0, 32'h0,        8'h00, 32'h00, 0);
        add(0, 0, 0, 0, 32'h0,        8'hA5, 32'h00, 0);
        add(0, 0, 0, 0, 32'h0,        8'hA5, 32'h00, 0);
        add(0, 0, 0, 0, 32'h0,        8'hA5, 32'hA5, 0);
        add(0, 1, 0, 1, 32'h0,        8'hA5, 32'h00, 0);
        add(0, 1, 0, 3, 32'h0,        8'hA5, 32'hA5, 0);
        add(0, 1, 1, 3, 32'hFF,       8'h00, 32'hA5, 0);
        add(0, 0, 0, 3, 32'h0,        8'h0F, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'h00, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'h00, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'h00, 32'h0F, 0);
        add(0, 1, 1, 2, 32'h01,       8'h00, 32'h00, 1);
        add(0, 1, 0, 2, 32'h0,        8'h00, 32'h01, 1);
        add(0, 1, 1, 3, 32'h05,       8'h00, 32'h0F, 0);
        add(0, 0, 0, 3, 32'h0,        8'h00, 32'h0A, 0);
        add(0, 1, 1, 3, 32'hFF,       8'h00, 32'h0A, 0);
        add(0, 0, 0, 3, 32'h0,        8'h00, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'h01, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'h01, 32'h00, 0);
        add(0, 1, 1, 3, 32'h01,       8'h01, 32'h00, 1);
        add(0, 0, 0, 3, 32'h0,        8'h01, 32'h01, 1);
        add(0, 1, 1, 3, 32'h01,       8'h01, 32'h01, 0);
        add(0, 0, 0, 3, 32'h0,        8'h01, 32'h00, 0);
        add(0, 1, 1, 2, 32'hFF,       8'hFF, 32'h01, 0);
        add(0, 0, 0, 3, 32'h0,        8'hFF, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'hFF, 32'h00, 1);
        add(1, 0, 0, 3, 32'h0,        8'hFF, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'hFF, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'hFF, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'hFF, 32'h00, 0);
        add(0, 0, 0, 3, 32'h0,        8'hFF, 32'hFF, 0);
        add(0, 1, 1, 2, 32'hFF,       8'hFF, 32'h00, 1);
        add(0, 0, 0, 3, 32'h0,        8'hFF, 32'hFF, 1);
        add(1, 0, 0, 3, 32'h0,        8'hFF, 32'h00, 0);
        add(0, 1, 1, 1, 32'hFFFFFFFF, 8'hFF, 32'h00, 0);
        add(0, 0, 0, 2, 32'h0,        8'hFF, 32'h00, 0);

        foreach (tbl[k]) begin
            cycle(tbl[k].r, tbl[k].c, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].p);
            chk($sformatf("tbl%0d_readdata", k), rd0, tbl[k].erd);
            chk($sformatf("tbl%0d_irq", k), {31'h0, irq0}, {31'h0, tbl[k].eirq});
        end

        // bit 3 pulse: rising, falling, then a single-cycle pulse
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 8'h00);
        hold(8'h00, 4);
        hold(8'h08, 5);
        read_cap("rise_b3", 8'h08, 8'h08, 8'h00, 8'h08, 8'h08);
        cycle(1'b0, 1'b1, 1'b1, 2'd3, 32'hFF, 8'h08);
        hold(8'h00, 5);
        read_cap("fall_b3", 8'h00, 8'h00, 8'h08, 8'h08, 8'h08);
        cycle(1'b0, 1'b1, 1'b1, 2'd3, 32'hFF, 8'h00);
        hold(8'h08, 1);
        hold(8'h00, 5);
        read_cap("pulse_b3", 8'h00, 8'h08, 8'h08, 8'h08, 8'h08);

        // randomized traffic against the model
        begin
            logic         r, c, w;
            logic [1:0]   a;
            logic [31:0]  d;
            logic [W-1:0] p;
            p = '0;
            for (int k = 0; k < 800; k++) begin
                r = ($urandom_range(0, 63) == 0);
                c = 1'($urandom_range(0, 1));
                w = 1'($urandom_range(0, 1));
                a = 2'($urandom_range(0, 3));
                d = $urandom;
                if ($urandom_range(0, 2) == 0) p = W'($urandom_range(0, 255));
                cycle(r, c, w, a, d, p);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
